// File: rtl/ps2_pkg.sv
// Shared scan-code constants, FSM state encoding and event packing helper
// for the PS/2 keyboard decoder.
package ps2_pkg;

    localparam logic [7:0] SC_EXT       = 8'hE0;
    localparam logic [7:0] SC_BRK       = 8'hF0;
    localparam logic [7:0] SC_PAUSE     = 8'hE1;
    localparam logic [7:0] SC_BAT_OK    = 8'hAA;
    localparam logic [7:0] SC_BAT_ERR   = 8'hFC;
    localparam logic [7:0] SC_PAUSE_EVT = 8'h77;

    localparam int PAUSE_LEN = 7;
    localparam int EVT_W     = 10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_PAUSE   = 3'd4
    } ps2_state_t;

    // Event word layout: {extended, break, code}
    function automatic logic [EVT_W-1:0] mk_evt(input logic ext, input logic brk,
                                                input logic [7:0] code);
        return {ext, brk, code};
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous FIFO for decoded key events; storage is not reset, only the
// pointers and occupancy count are.
module ps2_evt_fifo #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_W-1:0]          din,
    input  logic                       pop,
    output logic [DATA_W-1:0]          dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              pop_ok;
    logic              push_ok;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign pop_ok  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_kbd_decoder.sv
// PS/2 set-2 scan-code decoder: folds E0/F0/E1 prefixes into make/break
// events and queues them for a ready/valid consumer.
module ps2_kbd_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           rcv_data,
    input  logic                 rcv_vld,
    input  logic                 rcv_parity_err,
    output logic                 hold_req,
    output logic [EVT_W-1:0]     evt_data,
    output logic                 evt_vld,
    input  logic                 evt_rdy,
    output logic                 bat_ok,
    output logic                 bat_err,
    output logic                 frame_err,
    output logic                 overflow
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] HOLD_LVL   = CNT_W'(FIFO_DEPTH - 1);
    localparam logic [2:0]       PAUSE_LAST = 3'(PAUSE_LEN - 1);

    ps2_state_t       state, state_nxt;
    logic [2:0]       pcnt, pcnt_nxt;
    logic             push_req;
    logic [EVT_W-1:0] push_evt;
    logic             bat_ok_d, bat_err_d, frame_err_d;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count, count_nxt;
    logic             pop_ok, push_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            pcnt  <= '0;
        end else begin
            state <= state_nxt;
            pcnt  <= pcnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pcnt_nxt    = pcnt;
        push_req    = 1'b0;
        push_evt    = '0;
        bat_ok_d    = 1'b0;
        bat_err_d   = 1'b0;
        frame_err_d = 1'b0;
        if (rcv_vld) begin
            if (rcv_parity_err) begin
                frame_err_d = 1'b1;
                state_nxt   = ST_IDLE;
                pcnt_nxt    = '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        case (rcv_data)
                            SC_EXT:      state_nxt = ST_EXT;
                            SC_BRK:      state_nxt = ST_BRK;
                            SC_PAUSE: begin
                                state_nxt = ST_PAUSE;
                                pcnt_nxt  = '0;
                            end
                            SC_BAT_OK:   bat_ok_d    = 1'b1;
                            SC_BAT_ERR:  bat_err_d   = 1'b1;
                            8'h00, 8'hFF: frame_err_d = 1'b1;
                            default: begin
                                push_req = 1'b1;
                                push_evt = mk_evt(1'b0, 1'b0, rcv_data);
                            end
                        endcase
                    end
                    ST_EXT: begin
                        if (rcv_data == SC_BRK) begin
                            state_nxt = ST_EXT_BRK;
                        end else if (rcv_data != SC_EXT) begin
                            push_req  = 1'b1;
                            push_evt  = mk_evt(1'b1, 1'b0, rcv_data);
                            state_nxt = ST_IDLE;
                        end
                    end
                    ST_BRK: begin
                        push_req  = 1'b1;
                        push_evt  = mk_evt(1'b0, 1'b1, rcv_data);
                        state_nxt = ST_IDLE;
                    end
                    ST_EXT_BRK: begin
                        push_req  = 1'b1;
                        push_evt  = mk_evt(1'b1, 1'b1, rcv_data);
                        state_nxt = ST_IDLE;
                    end
                    ST_PAUSE: begin
                        // Pause has no break code; its tail is swallowed whole.
                        if (pcnt == PAUSE_LAST) begin
                            push_req  = 1'b1;
                            push_evt  = mk_evt(1'b1, 1'b0, SC_PAUSE_EVT);
                            state_nxt = ST_IDLE;
                            pcnt_nxt  = '0;
                        end else begin
                            pcnt_nxt = pcnt + 3'd1;
                        end
                    end
                    default: begin
                        state_nxt = ST_IDLE;
                        pcnt_nxt  = '0;
                    end
                endcase
            end
        end
    end

    ps2_evt_fifo #(
        .DATA_W (EVT_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .din   (push_evt),
        .pop   (evt_rdy),
        .dout  (evt_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign evt_vld   = !fifo_empty;
    assign pop_ok    = evt_rdy && !fifo_empty;
    assign push_ok   = push_req && (!fifo_full || pop_ok);
    assign count_nxt = fifo_count + CNT_W'(push_ok) - CNT_W'(pop_ok);

    // hold_req tracks the post-edge count so it lines up with the FIFO state.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_req  <= 1'b0;
            bat_ok    <= 1'b0;
            bat_err   <= 1'b0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            hold_req  <= (count_nxt >= HOLD_LVL);
            bat_ok    <= bat_ok_d;
            bat_err   <= bat_err_d;
            frame_err <= frame_err_d;
            overflow  <= push_req && !push_ok;
        end
    end

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// Directed bench for ps2_kbd_decoder: make/break, extended, Pause, parity,
// overflow, BAT and mid-sequence reset scenarios.
module tb_ps2_kbd_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rcv_data;
    logic       rcv_vld;
    logic       rcv_parity_err;
    logic       hold_req;
    logic [9:0] evt_data;
    logic       evt_vld;
    logic       evt_rdy;
    logic       bat_ok;
    logic       bat_err;
    logic       frame_err;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;

    ps2_kbd_decoder #(.FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .rcv_data       (rcv_data),
        .rcv_vld        (rcv_vld),
        .rcv_parity_err (rcv_parity_err),
        .hold_req       (hold_req),
        .evt_data       (evt_data),
        .evt_vld        (evt_vld),
        .evt_rdy        (evt_rdy),
        .bat_ok         (bat_ok),
        .bat_err        (bat_err),
        .frame_err      (frame_err),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    // One byte, one rcv_vld cycle; returns on the falling edge after the
    // capturing rising edge, where registered results are visible.
    task automatic send(input logic [7:0] b, input logic perr = 1'b0);
        @(negedge clk);
        rcv_data       = b;
        rcv_parity_err = perr;
        rcv_vld        = 1'b1;
        @(negedge clk);
        rcv_vld        = 1'b0;
        rcv_parity_err = 1'b0;
    endtask

    task automatic pop_one();
        evt_rdy = 1'b1;
        @(negedge clk);
        evt_rdy = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({evt_vld, hold_req, bat_ok, bat_err, frame_err, overflow} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, want 000000",
                     {evt_vld, hold_req, bat_ok, bat_err, frame_err, overflow});
        end
    endtask

    task automatic test_make_break();
        send(8'h1C);
        n_checks++;
        if (evt_vld !== 1'b1 || evt_data !== 10'h01C) begin
            n_fail++;
            $display("FAIL make_evt: vld=%b data=%h, want vld=1 data=01c", evt_vld, evt_data);
        end
        pop_one();
        send(8'hF0);
        n_checks++;
        if (evt_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL brk_prefix_no_evt: vld=%b, want 0", evt_vld);
        end
        send(8'h1C);
        n_checks++;
        if (evt_vld !== 1'b1 || evt_data !== 10'h11C) begin
            n_fail++;
            $display("FAIL break_evt: vld=%b data=%h, want vld=1 data=11c", evt_vld, evt_data);
        end
        pop_one();
        n_checks++;
        if (evt_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL make_break_drained: vld=%b, want 0", evt_vld);
        end
    endtask

    task automatic test_extended();
        send(8'hE0);
        send(8'h75);
        n_checks++;
        if (evt_vld !== 1'b1 || evt_data !== 10'h275) begin
            n_fail++;
            $display("FAIL ext_make: vld=%b data=%h, want vld=1 data=275", evt_vld, evt_data);
        end
        pop_one();
        send(8'hE0);
        send(8'hF0);
        n_checks++;
        if (evt_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL ext_brk_prefix_no_evt: vld=%b, want 0", evt_vld);
        end
        send(8'h75);
        n_checks++;
        if (evt_vld !== 1'b1 || evt_data !== 10'h375) begin
            n_fail++;
            $display("FAIL ext_break: vld=%b data=%h, want vld=1 data=375", evt_vld, evt_data);
        end
        pop_one();
    endtask

    task automatic test_pause();
        logic [7:0] tail [7] = '{8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        int early_evts = 0;
        send(8'hE1);
        for (int i = 0; i < 7; i++) begin
            send(tail[i]);
            if (i < 6 && evt_vld) early_evts++;
        end
        n_checks++;
        if (early_evts != 0) begin
            n_fail++;
            $display("FAIL pause_no_early_evt: got %0d events, want 0", early_evts);
        end
        n_checks++;
        if (evt_vld !== 1'b1 || evt_data !== 10'h277) begin
            n_fail++;
            $display("FAIL pause_evt: vld=%b data=%h, want vld=1 data=277", evt_vld, evt_data);
        end
        pop_one();
        n_checks++;
        if (evt_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_single_evt: vld=%b, want 0", evt_vld);
        end
    endtask

    task automatic test_parity();
        send(8'hE0);
        send(8'h75, 1'b1);
        n_checks++;
        if (frame_err !== 1'b1 || evt_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_frame_err: frame_err=%b vld=%b, want 1/0", frame_err, evt_vld);
        end
        send(8'h1C);
        n_checks++;
        if (frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_pulse_width: frame_err=%b, want 0", frame_err);
        end
        n_checks++;
        if (evt_vld !== 1'b1 || evt_data !== 10'h01C) begin
            n_fail++;
            $display("FAIL parity_resync_evt: vld=%b data=%h, want vld=1 data=01c", evt_vld, evt_data);
        end
        pop_one();
        n_checks++;
        if (evt_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_single_evt: vld=%b, want 0", evt_vld);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] codes [5] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
        for (int i = 0; i < 5; i++) begin
            send(codes[i]);
            if (i == 1) begin
                n_checks++;
                if (hold_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL hold_before_3rd: hold_req=%b, want 0", hold_req);
                end
            end
            if (i == 2) begin
                n_checks++;
                if (hold_req !== 1'b1) begin
                    n_fail++;
                    $display("FAIL hold_after_3rd: hold_req=%b, want 1", hold_req);
                end
            end
            if (i == 3) begin
                n_checks++;
                if (overflow !== 1'b0) begin
                    n_fail++;
                    $display("FAIL no_overflow_4th: overflow=%b, want 0", overflow);
                end
            end
            if (i == 4) begin
                n_checks++;
                if (overflow !== 1'b1) begin
                    n_fail++;
                    $display("FAIL overflow_5th: overflow=%b, want 1", overflow);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (evt_vld !== 1'b1 || evt_data !== {2'b00, codes[i]}) begin
                n_fail++;
                $display("FAIL drain_%0d: vld=%b data=%h, want vld=1 data=%h",
                         i, evt_vld, evt_data, {2'b00, codes[i]});
            end
            pop_one();
        end
        n_checks++;
        if (evt_vld !== 1'b0 || hold_req !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL drained_state: vld=%b hold=%b ovf=%b, want 0/0/0",
                     evt_vld, hold_req, overflow);
        end
    endtask

    task automatic test_bat();
        send(8'hAA);
        n_checks++;
        if (bat_ok !== 1'b1 || bat_err !== 1'b0 || evt_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL bat_ok: ok=%b err=%b vld=%b, want 1/0/0", bat_ok, bat_err, evt_vld);
        end
        @(negedge clk);
        n_checks++;
        if (bat_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL bat_ok_width: ok=%b, want 0", bat_ok);
        end
        send(8'hFC);
        n_checks++;
        if (bat_err !== 1'b1 || bat_ok !== 1'b0 || evt_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL bat_err: ok=%b err=%b vld=%b, want 0/1/0", bat_ok, bat_err, evt_vld);
        end
        send(8'h00);
        n_checks++;
        if (frame_err !== 1'b1 || bat_err !== 1'b0 || evt_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_byte: ferr=%b err=%b vld=%b, want 1/0/0", frame_err, bat_err, evt_vld);
        end
    endtask

    task automatic test_mid_reset();
        send(8'hF0);
        do_reset();
        n_checks++;
        if (evt_vld !== 1'b0 || hold_req !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: vld=%b hold=%b, want 0/0", evt_vld, hold_req);
        end
        send(8'h1C);
        n_checks++;
        if (evt_vld !== 1'b1 || evt_data !== 10'h01C) begin
            n_fail++;
            $display("FAIL mid_reset_make: vld=%b data=%h, want vld=1 data=01c", evt_vld, evt_data);
        end
        pop_one();
    endtask

    initial begin
        rst            = 1'b1;
        rcv_data       = 8'h00;
        rcv_vld        = 1'b0;
        rcv_parity_err = 1'b0;
        evt_rdy        = 1'b0;
        test_reset();
        test_make_break();
        test_extended();
        test_pause();
        test_parity();
        test_overflow();
        test_bat();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_decoder.md
PS2_KBD_DECODER -- requirements
Module: ps2_kbd_decoder

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, giving the event FIFO depth in entries (power of two, 2..16).
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all logic is on the rising edge.
REQ-003 The block SHALL have port rst, input, 1, the reset, which is synchronous and active-high.
REQ-004 The block SHALL have port rcv_data, input, 8, the received PS2 byte from the core; it is valid only with rcv_vld.
REQ-005 The block SHALL have port rcv_vld, input, 1, a one-cycle pulse per received byte.
REQ-006 The block SHALL have port rcv_parity_err, input, 1, qualified by rcv_vld, marking the byte as bad.
REQ-007 The block SHALL have port hold_req, output, 1, which asks the core to inhibit the device clock.
REQ-008 The block SHALL have port evt_data, output, 10, carrying {extended, break, code[7:0]} of the FIFO head.
REQ-009 The block SHALL have port evt_vld, output, 1, high while the FIFO is non-empty.
REQ-010 The block SHALL have port evt_rdy, input, 1; the consumer pops the FIFO when evt_vld and evt_rdy are both high.
REQ-011 The block SHALL have port bat_ok, output, 1, a one-cycle pulse when 0xAA is received in IDLE.
REQ-012 The block SHALL have port bat_err, output, 1, a one-cycle pulse when 0xFC is received in IDLE.
REQ-013 The block SHALL have port frame_err, output, 1, a one-cycle pulse on a parity error or a 0x00/0xFF byte in IDLE.
REQ-014 The block SHALL have port overflow, output, 1, a one-cycle pulse when an event is dropped because the FIFO is full.

Function
REQ-015 The block SHALL act only in cycles where rcv_vld=1; in all other cycles the FSM holds and the error and BAT pulses are 0.
REQ-016 The FSM SHALL have the states IDLE, EXT, BRK, EXT_BRK and PAUSE.
REQ-017 In IDLE, a byte SHALL be handled as follows:
- 0xE0 -> EXT.
- 0xF0 -> BRK.
- 0xE1 -> PAUSE, with pcnt=0.
- 0xAA -> bat_ok pulse; 0xFC -> bat_err pulse; 0x00/0xFF -> frame_err pulse; each stays in IDLE with no event.
- Any other byte -> push {0,0,byte}.
REQ-018 In EXT, 0xF0 SHALL go to EXT_BRK, 0xE0 SHALL stay in EXT, and any other byte SHALL push {1,0,byte} and return to IDLE.
REQ-019 In BRK, any byte SHALL push {0,1,byte} and return to IDLE; in EXT_BRK, any byte SHALL push {1,1,byte} and return to IDLE.
REQ-020 In PAUSE, the next 7 bytes SHALL be consumed without parsing (pcnt counts 0..6); on the 7th byte the block SHALL push {1,0,0x77} and return to IDLE.
REQ-021 A byte with rcv_parity_err=1 in any state SHALL be discarded, pulse frame_err, force IDLE, clear pcnt and push nothing.
REQ-022 A push SHALL make evt_data/evt_vld visible in the cycle after the rcv_vld cycle when the FIFO was empty (latency 1).
REQ-023 A push SHALL be accepted when count<FIFO_DEPTH, or when count==FIFO_DEPTH and a pop occurs in the same cycle.
REQ-024 In all other cases a push SHALL be dropped with an overflow pulse; the FSM SHALL still advance.
REQ-025 A simultaneous push and pop SHALL leave count unchanged; the FIFO SHALL keep order, and its pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 hold_req SHALL be registered and equal 1 iff count >= FIFO_DEPTH-1, leaving one slot for a byte already in flight.
REQ-027 evt_data SHALL hold stable while evt_vld=1 and evt_rdy=0.

Reset
REQ-028 On rst=1 at a clock edge, the block SHALL set the FSM to IDLE, pcnt=0 and the FIFO empty (count=0, pointers 0).
REQ-029 On reset, the block SHALL set evt_vld=0, hold_req=0, bat_ok=0, bat_err=0, frame_err=0 and overflow=0; evt_data is don't-care while evt_vld=0.
REQ-030 Reset in the middle of a multi-byte sequence SHALL abandon the sequence; the next byte is parsed from IDLE.

Structure
REQ-031 The scan-code constants (0xE0, 0xF0, 0xE1, 0xAA, 0xFC, 0x77), the PAUSE_LEN=7 constant and the FSM state encodings SHALL live in the shared package ps2_pkg.
REQ-032 The FIFO SHALL be a single sub-module, ps2_evt_fifo: a synchronous FIFO of parameter width and depth, with push, pop, full, empty and count.

Verification
REQ-033 The bench SHALL check a make/break sequence: bytes 0x1C, then 0xF0 0x1C -> events 0x01C then 0x11C, with evt_vld one cycle after each final byte.
REQ-034 The bench SHALL check an extended key: bytes 0xE0 0x75, then 0xE0 0xF0 0x75 -> events 0x275 then 0x375.
REQ-035 The bench SHALL check Pause: E1 14 77 E1 F0 14 F0 77 -> exactly one event, 0x277; no events for the intermediate bytes.
REQ-036 The bench SHALL check a parity error: E0 then a byte with rcv_parity_err=1, then 0x1C -> frame_err pulse and a single event 0x01C.
REQ-037 The bench SHALL check overflow: with evt_rdy=0 and FIFO_DEPTH=4, send 5 make codes -> hold_req=1 after the 3rd push, the 5th byte pulses overflow, and draining yields the first 4 codes in order.
REQ-038 The bench SHALL check BAT codes and mid-sequence reset: 0xAA -> bat_ok pulse; 0xFC -> bat_err pulse; 0xF0, then rst, then 0x1C -> event 0x01C (a make, not a break).
